// File: rtl/bit8div_pkg.sv
// Shared constants, FSM state type and sign helper for the bit8div divider.
package bit8div_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;
  localparam int PR_W   = DATA_W + 1;

  localparam logic [CNT_W-1:0]  LAST_ITER = 4'd7;
  localparam logic [DATA_W-1:0] DZ_QUOT   = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Two's-complement magnitude when neg is set, pass-through otherwise.
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/bit8div_if.sv
// Request/result bundle for bit8div: operands and start in, status and results out.
interface bit8div_if;
  import bit8div_pkg::*;

  logic              start;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] quot;
  logic [DATA_W-1:0] rem;
  logic              dz;
  logic              ovf;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quot, rem, dz, ovf
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quot, rem, dz, ovf
  );
endinterface

// File: rtl/bit8div_step.sv
// One combinational restoring shift-subtract step of the divider.
module bit8div_step
  import bit8div_pkg::*;
(
  input  logic [PR_W-1:0]   pr_in,
  input  logic              dbit,
  input  logic [DATA_W-1:0] dsr,
  output logic [PR_W-1:0]   pr_out,
  output logic              qbit
);

  logic [PR_W:0] shifted;

  // Shift next dividend bit in, subtract divisor when it fits, otherwise restore.
  always_comb begin
    shifted = {pr_in, dbit};
    qbit    = (shifted >= {2'b00, dsr});
    pr_out  = qbit ? PR_W'(shifted - {2'b00, dsr}) : PR_W'(shifted);
  end

endmodule

// File: rtl/bit8div.sv
// 8-bit iterative restoring divider, 8 steps per operation.
// Optional signed mode via macro BIT8DIV_SIGNED_EN (adds port sgn).
module bit8div (
  input  logic     clk,
  input  logic     rst_n,
`ifdef BIT8DIV_SIGNED_EN
  input  logic     sgn,
`endif
  bit8div_if.slave io
);
  import bit8div_pkg::*;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] dvd, dsr, dvd_orig, qacc;
  logic [PR_W-1:0]   pr;
  logic              neg_q, neg_r, dz_c;
  logic              busy_r, done_r, dz_r;
  logic [DATA_W-1:0] quot_r, rem_r;

  logic [PR_W-1:0]   step_rem;
  logic              step_q;
  logic [DATA_W-1:0] qfin, rfin;
  logic              neg_a, neg_b;

  bit8div_step u_step (
    .pr_in  (pr),
    .dbit   (dvd[DATA_W-1]),
    .dsr    (dsr),
    .pr_out (step_rem),
    .qbit   (step_q)
  );

  // Final quotient/remainder as they stand after the current step.
  always_comb begin
    qfin = {qacc[DATA_W-2:0], step_q};
    rfin = step_rem[DATA_W-1:0];
  end

`ifdef BIT8DIV_SIGNED_EN
  logic ovf_c, ovf_r, ovf_in;

  // Operand sign decode for signed mode; -128/-1 is the only overflow case.
  always_comb begin
    neg_a  = sgn & io.dividend[DATA_W-1];
    neg_b  = sgn & io.divisor[DATA_W-1];
    ovf_in = sgn & (io.dividend == 8'h80) & (io.divisor == 8'hFF);
  end

  // Overflow flag captured at accept and published with the results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_c <= 1'b0;
      ovf_r <= 1'b0;
    end else if (state != RUN && io.start) begin
      ovf_c <= ovf_in;
    end else if (state == RUN && cnt == LAST_ITER) begin
      ovf_r <= ovf_c;
    end
  end

  assign io.ovf = ovf_r;
`else
  // Unsigned-only build: operands are never negated.
  always_comb begin
    neg_a = 1'b0;
    neg_b = 1'b0;
  end

  assign io.ovf = 1'b0;
`endif

  // Control FSM, iteration datapath and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      dvd_orig <= '0;
      qacc     <= '0;
      pr       <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz_c     <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      quot_r   <= '0;
      rem_r    <= '0;
      dz_r     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (io.start) begin
            // Divide magnitudes; signs are reapplied after the last step.
            dvd      <= mag(io.dividend, neg_a);
            dsr      <= mag(io.divisor, neg_b);
            dvd_orig <= io.dividend;
            neg_q    <= neg_a ^ neg_b;
            neg_r    <= neg_a;
            dz_c     <= (io.divisor == '0);
            pr       <= '0;
            qacc     <= '0;
            cnt      <= '0;
            busy_r   <= 1'b1;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          pr   <= step_rem;
          dvd  <= {dvd[DATA_W-2:0], 1'b0};
          qacc <= qfin;
          cnt  <= cnt + 4'd1;
          if (cnt == LAST_ITER) begin
            quot_r <= dz_c ? DZ_QUOT  : mag(qfin, neg_q);
            rem_r  <= dz_c ? dvd_orig : mag(rfin, neg_r);
            dz_r   <= dz_c;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.busy = busy_r;
  assign io.done = done_r;
  assign io.quot = quot_r;
  assign io.rem  = rem_r;
  assign io.dz   = dz_r;

endmodule

// File: tb/tb_bit8div.sv
// Self-checking bench for bit8div: vector table plus hand-written corner sequences,
// expected results queued at accept and compared when done pulses.
module tb_bit8div;

  localparam int LAT_EDGES = 9;   // accept edge E0 counts as edge 1
  localparam int BOUND     = 30;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef BIT8DIV_SIGNED_EN
  logic sgn = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  vec_t vecs[$];
  vec_t sb[$];

  bit8div_if io ();

  bit8div dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef BIT8DIV_SIGNED_EN
    .sgn   (sgn),
`endif
    .io    (io)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model from integer arithmetic (truncating division, rem takes dividend sign).
  function automatic vec_t model(input logic [7:0] a, input logic [7:0] b, input logic s);
    vec_t v;
    int ia, ib, iq, ir;
    v.a = a; v.b = b; v.s = s; v.dz = 1'b0; v.ovf = 1'b0;
    ia = s ? int'($signed(a)) : int'(a);
    ib = s ? int'($signed(b)) : int'(b);
    if (b == 8'h00) begin
      v.q = 8'hFF; v.r = a; v.dz = 1'b1;
    end else if (s && a == 8'h80 && b == 8'hFF) begin
      v.q = 8'h80; v.r = 8'h00; v.ovf = 1'b1;
    end else begin
      iq = ia / ib;
      ir = ia % ib;
      v.q = iq[7:0];
      v.r = ir[7:0];
    end
    return v;
  endfunction

  task automatic drive_start(input logic [7:0] a, input logic [7:0] b, input logic s);
    @(negedge clk);
    io.start    = 1'b1;
    io.dividend = a;
    io.divisor  = b;
`ifdef BIT8DIV_SIGNED_EN
    sgn = s;
`else
    if (s) $display("signed vector requested in unsigned build");
`endif
  endtask

  task automatic compare_result(input string tag);
    vec_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_quot"}, io.quot, e.q);
    check({tag, "_rem"},  io.rem,  e.r);
    check({tag, "_dz"},   io.dz,   e.dz);
    check({tag, "_ovf"},  io.ovf,  e.ovf);
    check({tag, "_busy_at_done"}, io.busy, 0);
  endtask

  // One full operation: accept, latency, results, single-cycle done.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s);
    int edges;
    drive_start(a, b, s);
    @(posedge clk);
    sb.push_back(model(a, b, s));
    #1;
    io.start = 1'b0;
    check({tag, "_busy_after_accept"}, io.busy, 1);
    edges = 1;
    while (!io.done && edges < BOUND) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "_latency"}, edges, LAT_EDGES);
    if (io.done) compare_result(tag);
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, io.done, 0);
  endtask

  initial begin
    int ndone;
    int edges;

    io.start = 1'b0;
    io.dividend = '0;
    io.divisor = '0;

    vecs.push_back(model(8'd100, 8'd7,   1'b0));
    vecs.push_back(model(8'd255, 8'd1,   1'b0));
    vecs.push_back(model(8'd3,   8'd200, 1'b0));
    vecs.push_back(model(8'd5,   8'd0,   1'b0));
    vecs.push_back(model(8'd0,   8'd5,   1'b0));
    vecs.push_back(model(8'd255, 8'd255, 1'b0));
    vecs.push_back(model(8'd200, 8'd13,  1'b0));
    vecs.push_back(model(8'd128, 8'd16,  1'b0));
    vecs.push_back(model(8'd0,   8'd0,   1'b0));
`ifdef BIT8DIV_SIGNED_EN
    vecs.push_back(model(8'hF9, 8'h02, 1'b1));   // -7 / 2
    vecs.push_back(model(8'h80, 8'hFF, 1'b1));   // -128 / -1
    vecs.push_back(model(8'h07, 8'hFE, 1'b1));   // 7 / -2
    vecs.push_back(model(8'hF9, 8'h00, 1'b1));   // -7 / 0
    vecs.push_back(model(8'hF9, 8'h02, 1'b0));   // 249 / 2 unsigned
`endif

    // Reset state
    #12;
    check("rst_busy", io.busy, 0);
    check("rst_done", io.done, 0);
    check("rst_quot", io.quot, 0);
    check("rst_rem",  io.rem,  0);
    check("rst_dz",   io.dz,   0);
    check("rst_ovf",  io.ovf,  0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d_%0d_%0d", i, vecs[i].a, vecs[i].b), vecs[i].a, vecs[i].b, vecs[i].s);
    end

    // Start pulsed at E3 with new operands while running: must be ignored
    drive_start(8'd100, 8'd7, 1'b0);
    @(posedge clk);
    sb.push_back(model(8'd100, 8'd7, 1'b0));
    #1 io.start = 1'b0;
    repeat (2) @(posedge clk);
    drive_start(8'd50, 8'd3, 1'b0);
    @(posedge clk);
    #1 io.start = 1'b0;
    ndone = 0;
    edges = 4;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      edges++;
      if (io.done) begin
        ndone++;
        if (ndone == 1) begin
          check("ignore_latency", edges, LAT_EDGES);
          compare_result("ignore");
        end
      end
    end
    check("ignore_done_count", ndone, 1);

    // Reset asserted just before E4: outputs clear at once, no done afterwards
    drive_start(8'd200, 8'd9, 1'b0);
    @(posedge clk);
    #1 io.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midrst_busy_before", io.busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", io.busy, 0);
    check("midrst_done", io.done, 0);
    check("midrst_quot", io.quot, 0);
    check("midrst_rem",  io.rem,  0);
    check("midrst_dz",   io.dz,   0);
    check("midrst_ovf",  io.ovf,  0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (io.done || io.busy) ndone++;
    end
    check("midrst_no_done_no_busy", ndone, 0);
    run_op("after_rst_20_6", 8'd20, 8'd6, 1'b0);

    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
